// File: rtl/shaping_pkg.sv
// Shared types, widths and limits for the detector-pulse emulator and shaper datapath.
package shaping_pkg;

  localparam int FRAC = 8;
  localparam int SW   = 14;
  localparam int AW   = SW + 1 + FRAC - 1 + 1;   // 23: sign + 14 integer + 8 fraction
  localparam int AMPW = SW - 1;

  typedef enum logic {
    IDLE  = 1'b0,
    DECAY = 1'b1
  } state_t;

  localparam int YMAX = ((2 ** (SW - 1)) - 1) * (2 ** FRAC);

  localparam logic signed [SW-1:0] S_MAX = 14'sh1FFF;
  localparam logic signed [SW-1:0] S_MIN = 14'sh2000;
  localparam logic signed [SW+1:0] S_HI  = 16'sd8191;
  localparam logic signed [SW+1:0] S_LO  = -16'sd8192;

  // Clamp a widened signed sample to 14 bits and emit offset binary.
  function automatic logic [SW-1:0] ob_encode(input logic signed [SW+1:0] v);
    logic signed [SW-1:0] s;
    if (v > S_HI)      s = S_MAX;
    else if (v < S_LO) s = S_MIN;
    else               s = v[SW-1:0];
    return {~s[SW-1], s[SW-2:0]};
  endfunction

endpackage

// File: rtl/shaping_ob_enc.sv
// Baseline add, 14-bit signed clamp and offset-binary encode of an integer sample.
module shaping_ob_enc
  import shaping_pkg::*;
(
  input  logic signed [SW-1:0]      base,
  input  logic signed [AW-FRAC-1:0] val,
  output logic        [SW-1:0]      code
);

  logic signed [SW+1:0] sum;

  always_comb begin
    sum  = $signed({{2{base[SW-1]}}, base}) + $signed({val[AW-FRAC-1], val});
    code = ob_encode(sum);
  end

endmodule

// File: rtl/shaping_pulse_gen.sv
// Preamp-style pulse emulator: step plus exponential decay with pile-up on a baseline.
module shaping_pulse_gen
  import shaping_pkg::*;
#(
  parameter int unsigned PERIOD      = 4096,
  parameter int unsigned DECAY_SHIFT = 6,
  parameter int          BASELINE    = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            ste,
  input  logic            trig,
  input  logic            auto,
  input  logic [AMPW-1:0] amp,
  output logic [SW-1:0]   outp,
  output logic            pulse,
  output logic            busy,
  output logic [15:0]     pulse_cnt
);

  localparam int unsigned PW = $clog2(PERIOD);
  localparam logic [PW-1:0]        PLAST    = PW'(PERIOD - 1);
  localparam logic signed [SW-1:0] BASE     = SW'(BASELINE);
  localparam logic [SW-1:0]        OUT_IDLE = ob_encode((SW+2)'(BASELINE));

  state_t               state, state_nxt;
  logic signed [AW-1:0] y, y_nxt, dec;
  logic signed [AW:0]   acc;
  logic                 pend, pend_nxt;
  logic [PW-1:0]        pcnt, pcnt_nxt;
  logic                 fire;
  logic [SW-1:0]        code;

  always_comb begin
    state_nxt = state;
    y_nxt     = y;
    pend_nxt  = pend | trig;
    pcnt_nxt  = pcnt;
    fire      = 1'b0;
    dec       = y >>> DECAY_SHIFT;
    acc       = $signed({y[AW-1], y}) + $signed({3'b000, amp, 8'h00});
    if (ste) begin
      pend_nxt = 1'b0;
      pcnt_nxt = (pcnt == PLAST) ? '0 : pcnt + PW'(1);
      fire     = pend | trig | (auto && (pcnt == PLAST));
      if (fire) begin
        y_nxt     = (acc > (AW+1)'(YMAX)) ? AW'(YMAX) : acc[AW-1:0];
        state_nxt = (y_nxt != '0) ? DECAY : IDLE;
      end else if (state == DECAY) begin
        // Residue below one decay step would never reach zero; snap it to idle.
        if (dec == '0) begin
          y_nxt     = '0;
          state_nxt = IDLE;
        end else begin
          y_nxt = y - dec;
        end
      end
    end
    if (!en) begin
      state_nxt = IDLE;
      y_nxt     = '0;
      pend_nxt  = 1'b0;
      pcnt_nxt  = '0;
      fire      = 1'b0;
    end
  end

  shaping_ob_enc u_enc (
    .base (BASE),
    .val  (y_nxt[AW-1:FRAC]),
    .code (code)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      y         <= '0;
      pend      <= 1'b0;
      pcnt      <= '0;
      outp      <= OUT_IDLE;
      pulse     <= 1'b0;
      busy      <= 1'b0;
      pulse_cnt <= '0;
    end else begin
      state <= state_nxt;
      y     <= y_nxt;
      pend  <= pend_nxt;
      pcnt  <= pcnt_nxt;
      outp  <= code;
      pulse <= fire;
      busy  <= (state_nxt == DECAY);
      if (fire) pulse_cnt <= pulse_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_shaping_pulse_gen.sv
// Directed bench for shaping_pulse_gen: reset, decay, pile-up, auto-fire, soft clear, wrap.
module tb_shaping_pulse_gen;

  logic        clk = 1'b0;
  logic        rst_n, en, en_n, ste, trig, auto;
  logic [12:0] amp;
  logic [13:0] outp, outp_n;
  logic        pulse, busy, pulse_n, busy_n;
  logic [15:0] cnt, cnt_n;

  int vec  = 0;
  int errs = 0;
  int ym, d;

  always #5 clk = ~clk;

  shaping_pulse_gen #(.PERIOD(16), .DECAY_SHIFT(6), .BASELINE(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ste(ste), .trig(trig), .auto(auto),
    .amp(amp), .outp(outp), .pulse(pulse), .busy(busy), .pulse_cnt(cnt)
  );

  shaping_pulse_gen #(.PERIOD(16), .DECAY_SHIFT(6), .BASELINE(-8000)) u_neg (
    .clk(clk), .rst_n(rst_n), .en(en_n), .ste(ste), .trig(trig), .auto(auto),
    .amp(amp), .outp(outp_n), .pulse(pulse_n), .busy(busy_n), .pulse_cnt(cnt_n)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic strobe();
    ste = 1'b1;
    tick(1);
    ste = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; en_n = 1'b0;
    ste = 1'b0; trig = 1'b0; auto = 1'b0; amp = '0;
    tick(1);
    ste = 1'b1; trig = 1'b1; auto = 1'b1; amp = 13'd1000;
    tick(2);
    chk("rst_outp", outp, 14'h2000);
    chk("rst_pulse", pulse, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cnt", cnt, 16'h0000);
    chk("rst_neg_outp", outp_n, 14'h00C0);

    rst_n = 1'b1; ste = 1'b0; trig = 1'b0; auto = 1'b0;
    tick(1);
    chk("post_rst_outp", outp, 14'h2000);

    // single pulse amp=1000, trigger ahead of strobe
    trig = 1'b1;
    tick(1);
    trig = 1'b0;
    tick(2);
    strobe();
    chk("fire_outp", outp, 14'h23E8);
    chk("fire_pulse", pulse, 1'b1);
    chk("fire_busy", busy, 1'b1);
    chk("fire_cnt", cnt, 16'd1);
    tick(1);
    chk("pulse_width", pulse, 1'b0);
    chk("hold_outp", outp, 14'h23E8);
    tick(6);
    strobe();
    chk("decay1_outp", outp, 14'h23D8);
    ym = 252000;
    for (int i = 0; i < 1000 && ym != 0; i++) begin
      tick(1);
      strobe();
      d  = ym >>> 6;
      ym = (d == 0) ? 0 : ym - d;
      chk("decay_outp", outp, 32'h2000 + (ym / 256));
      chk("decay_busy", busy, (ym != 0));
    end
    chk("idle_outp", outp, 14'h2000);
    chk("idle_busy", busy, 1'b0);
    chk("idle_cnt", cnt, 16'd1);

    // pile-up: amp=6000 twice, 4 strobes apart
    amp = 13'd6000; trig = 1'b1;
    strobe();
    trig = 1'b0;
    chk("pile1_outp", outp, 14'h3770);
    chk("pile1_cnt", cnt, 16'd2);
    strobe();
    chk("pile_dec_outp", outp, 14'h3712);
    strobe();
    strobe();
    trig = 1'b1;
    strobe();
    trig = 1'b0;
    chk("pile2_outp", outp, 14'h3FFF);
    chk("pile2_pulse", pulse, 1'b1);
    chk("pile2_cnt", cnt, 16'd3);
    chk("pile2_busy", busy, 1'b1);
    strobe();
    chk("sat_dec_outp", outp, 14'h3F7F);

    // soft clear mid-decay
    en = 1'b0;
    tick(1);
    chk("clr_outp", outp, 14'h2000);
    chk("clr_busy", busy, 1'b0);
    chk("clr_cnt", cnt, 16'd3);

    // auto-fire every 16 strobes with continuous ste
    amp = 13'd100; auto = 1'b1; ste = 1'b1; en = 1'b1;
    tick(15);
    chk("auto_early", pulse, 1'b0);
    tick(1);
    chk("auto1_pulse", pulse, 1'b1);
    chk("auto1_cnt", cnt, 16'd4);
    tick(15);
    chk("auto_gap", pulse, 1'b0);
    tick(1);
    chk("auto2_pulse", pulse, 1'b1);
    chk("auto2_cnt", cnt, 16'd5);
    tick(15);
    trig = 1'b1;
    tick(1);
    trig = 1'b0;
    chk("coinc_pulse", pulse, 1'b1);
    chk("coinc_cnt", cnt, 16'd6);
    tick(1);
    chk("coinc_after", pulse, 1'b0);
    chk("coinc_after_cnt", cnt, 16'd6);
    auto = 1'b0; ste = 1'b0;
    tick(1);

    // negative baseline, amp=0 fires, counter wrap
    en_n = 1'b1; amp = '0; trig = 1'b1; ste = 1'b1;
    tick(1);
    chk("neg_outp", outp_n, 14'h00C0);
    chk("neg_pulse", pulse_n, 1'b1);
    chk("neg_busy", busy_n, 1'b0);
    chk("neg_cnt", cnt_n, 16'd1);
    tick(65534);
    chk("cnt_ffff", cnt_n, 16'hFFFF);
    tick(1);
    chk("cnt_wrap", cnt_n, 16'h0000);
    chk("wrap_pulse", pulse_n, 1'b1);
    trig = 1'b0; ste = 1'b0;
    tick(1);
    chk("neg_quiet_pulse", pulse_n, 1'b0);
    chk("neg_quiet_outp", outp_n, 14'h00C0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
